dmem_arbiter: RTL and testbench

Two-master arbiter sharing the single-port data_memory between the CPU datapath (master 0) and a debug/loader port (master 1).
- Fixed priority to master 0, with a starvation limit that forces a master 1 grant.
- Every accepted access is registered into a one-stage issue register that drives data_memory.
- Read data comes back through a registered response stage.
- Sits between datapath/loader and data_memory; data_memory is unchanged.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned STARVE_W   = 4;

  localparam logic SRC_M0 = 1'b0;
  localparam logic SRC_M1 = 1'b1;

  // One memory access as held in the issue register
  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational fixed-priority pick with a starvation override for master 1.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                m0_req,
  input  logic                m1_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                gnt0,
  output logic                gnt1
);

  logic starved;

  // Master 1 wins when master 0 is idle or has hit its consecutive-grant limit
  always_comb begin
    starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    gnt1    = m1_req & (~m0_req | starved);
    gnt0    = m0_req & ~gnt1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory.
// Accepted accesses go through a one-stage issue register; read data returns
// through a registered response stage (accept N, access N+1, rvalid N+2).
// Optional grant/conflict counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ARB_ADDR_W,
  parameter int unsigned DATA_W       = ARB_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_m0_cnt,
  output logic [15:0]       perf_m1_cnt,
  output logic [15:0]       perf_conflict_cnt
`endif
);

  logic                pick_gnt0, pick_gnt1;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                iss_valid_q, iss_valid_d;
  logic                iss_src_q, iss_src_d;
  mem_req_t            iss_q, iss_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_src_q, rsp_src_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  dmem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .starve_cnt (starve_q),
    .gnt0       (pick_gnt0),
    .gnt1       (pick_gnt1)
  );

  // No grant may be given while reset is held
  assign m0_gnt = pick_gnt0 & ~reset;
  assign m1_gnt = pick_gnt1 & ~reset;

  // Next-state for starvation counter, issue stage and response stage
  always_comb begin
    starve_d    = starve_q;
    iss_valid_d = m0_gnt | m1_gnt;
    iss_src_d   = iss_src_q;
    iss_d       = iss_q;
    rsp_valid_d = iss_valid_q & ~iss_q.we;
    rsp_src_d   = iss_src_q;
    rsp_data_d  = rsp_data_q;

    if (!m1_req || m1_gnt) begin
      starve_d = '0;
    end else if (m0_gnt && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end

    if (m1_gnt) begin
      iss_src_d   = SRC_M1;
      iss_d.we    = m1_we;
      iss_d.addr  = ARB_ADDR_W'(m1_addr);
      iss_d.wdata = ARB_DATA_W'(m1_wdata);
    end else if (m0_gnt) begin
      iss_src_d   = SRC_M0;
      iss_d.we    = m0_we;
      iss_d.addr  = ARB_ADDR_W'(m0_addr);
      iss_d.wdata = ARB_DATA_W'(m0_wdata);
    end

    if (rsp_valid_d) begin
      rsp_data_d = mem_read_data;
    end
  end

  // Pipeline registers; reset drops whatever sits in the issue stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_src_q   <= SRC_M0;
      iss_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= SRC_M0;
      rsp_data_q  <= '0;
    end else begin
      starve_q    <= starve_d;
      iss_valid_q <= iss_valid_d;
      iss_src_q   <= iss_src_d;
      iss_q       <= iss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mem_access_addr = ADDR_W'(iss_q.addr);
  assign mem_write_data  = DATA_W'(iss_q.wdata);
  assign mem_write_en    = iss_valid_q & iss_q.we;
  assign mem_read_en     = iss_valid_q & ~iss_q.we;

  assign m0_rvalid = rsp_valid_q & (rsp_src_q == SRC_M0);
  assign m1_rvalid = rsp_valid_q & (rsp_src_q == SRC_M1);
  assign m0_rdata  = m0_rvalid ? rsp_data_q : '0;
  assign m1_rdata  = m1_rvalid ? rsp_data_q : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_m0_q, perf_m0_d;
  logic [15:0] perf_m1_q, perf_m1_d;
  logic [15:0] perf_cf_q, perf_cf_d;

  // Saturating grant and conflict counters
  always_comb begin
    perf_m0_d = perf_m0_q;
    perf_m1_d = perf_m1_q;
    perf_cf_d = perf_cf_q;
    if (m0_gnt && (perf_m0_q != 16'hFFFF)) perf_m0_d = perf_m0_q + 16'd1;
    if (m1_gnt && (perf_m1_q != 16'hFFFF)) perf_m1_d = perf_m1_q + 16'd1;
    if (m0_req && m1_req && (perf_cf_q != 16'hFFFF)) perf_cf_d = perf_cf_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_m0_q <= '0;
      perf_m1_q <= '0;
      perf_cf_q <= '0;
    end else begin
      perf_m0_q <= perf_m0_d;
      perf_m1_q <= perf_m1_d;
      perf_cf_q <= perf_cf_d;
    end
  end

  assign perf_m0_cnt       = perf_m0_q;
  assign perf_m1_cnt       = perf_m1_q;
  assign perf_conflict_cnt = perf_cf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed plan steps followed by
// randomized two-master traffic, checked against a transaction-level model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_m0_cnt, perf_m1_cnt, perf_conflict_cnt;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_PERF_EN
    , .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt),
    .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write on rising edge
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_access_addr[7:2]] <= mem_write_data;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end
  assign mem_read_data = mem[mem_access_addr[7:2]];

  // Reference model state
  typedef struct {
    int          acc;
    bit          src;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] old;
  } op_t;

  op_t         q[$];
  logic [31:0] shadow [64];
  int          n_cmp = 0, n_err = 0, t = 0, run = 0;
  int          pc0 = 0, pc1 = 0, pcc = 0;
  bit          p0_v = 0, p0_we = 0, p1_v = 0, p1_we = 0;
  logic [31:0] p0_a = '0, p0_d = '0, p1_a = '0, p1_d = '0;
  logic [11:0] pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt0"},  32'(m0_gnt), 32'd0);
    chk({tag, "_gnt1"},  32'(m1_gnt), 32'd0);
    chk({tag, "_we"},    32'(mem_write_en), 32'd0);
    chk({tag, "_re"},    32'(mem_read_en), 32'd0);
    chk({tag, "_addr"},  mem_access_addr, 32'd0);
    chk({tag, "_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_rv0"},   32'(m0_rvalid), 32'd0);
    chk({tag, "_rv1"},   32'(m1_rvalid), 32'd0);
    chk({tag, "_rd0"},   m0_rdata, 32'd0);
    chk({tag, "_rd1"},   m1_rdata, 32'd0);
  endtask

  // Record an accepted access; reads capture memory as seen after all earlier accepts
  task automatic accept(input bit src, input bit we, input logic [31:0] a, input logic [31:0] d);
    op_t op;
    op.acc = t; op.src = src; op.we = we; op.addr = a; op.wdata = d;
    op.old = shadow[a[7:2]];
    op.rdata = shadow[a[7:2]];
    if (we) shadow[a[7:2]] = d;
    q.push_back(op);
  endtask

  // One clock cycle: drive pending requests, check all outputs, advance the model
  task automatic step();
    bit e0, e1, fi, fr, m1_was;
    op_t iss, rsp;
    @(negedge clk);
    t++;
    m0_req = p0_v; m0_we = p0_we; m0_addr = p0_a; m0_wdata = p0_d;
    m1_req = p1_v; m1_we = p1_we; m1_addr = p1_a; m1_wdata = p1_d;
    #1;
    e1 = p1_v && (!p0_v || run >= LIMIT);
    e0 = p0_v && !e1;
    fi = 0; fr = 0;
    foreach (q[i]) begin
      if (q[i].acc == t - 1) begin fi = 1; iss = q[i]; end
      if (q[i].acc == t - 2 && !q[i].we) begin fr = 1; rsp = q[i]; end
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    chk("mem_write_en", 32'(mem_write_en), 32'(fi && iss.we));
    chk("mem_read_en",  32'(mem_read_en),  32'(fi && !iss.we));
    if (fi) begin
      chk("mem_access_addr", mem_access_addr, iss.addr);
      if (iss.we) chk("mem_write_data", mem_write_data, iss.wdata);
    end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(fr && !rsp.src));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(fr && rsp.src));
    chk("m0_rdata", m0_rdata, (fr && !rsp.src) ? rsp.rdata : 32'd0);
    chk("m1_rdata", m1_rdata, (fr && rsp.src) ? rsp.rdata : 32'd0);
    m1_was = p1_v;
    if (p0_v && p1_v) pcc++;
    if (e1) begin accept(1'b1, p1_we, p1_a, p1_d); p1_v = 0; pc1++; end
    else if (e0) begin accept(1'b0, p0_we, p0_a, p0_d); p0_v = 0; pc0++; end
    if (!m1_was || e1) run = 0;
    else if (e0) run++;
    while (q.size() > 0 && q[0].acc <= t - 2) void'(q.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

    // Preload memory while reset is held
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = 32'hA500_0000 | 32'(i);
      if (i == 8)  v = 32'h1234_5678;
      if (i == 12) v = 32'h0BAD_F00D;
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i); pl_val = v;
      shadow[i] = v;
    end
    @(negedge clk);
    pl_en = 1'b0;
    m0_req = 1; m1_req = 1;
    #1;
    chk_zero("reset_state");
    m0_req = 0; m1_req = 0;
    reset = 1'b0;

    // m0 write then read-back of the same word
    p0_v = 1; p0_we = 1; p0_a = 32'h10; p0_d = 32'hDEAD_BEEF;
    step();
    p0_v = 1; p0_we = 0; p0_a = 32'h10;
    step();
    step();
    step();
    chk("plan_wr_rd", m0_rdata, 32'hDEAD_BEEF);
    step();

    // Both masters requesting continuously: m1 forced every fifth grant
    for (int i = 0; i < 12; i++) begin
      if (!p0_v) begin p0_v = 1; p0_we = 0; p0_a = 32'h0; end
      if (!p1_v) begin p1_v = 1; p1_we = 0; p1_a = 32'h4; end
      step();
      pat[i] = m1_gnt;
    end
    chk("starve_pattern", 32'(pat), 32'h210);
    p0_v = 0; p1_v = 0;
    step(); step(); step();

    // m1 alone reads a preloaded word
    p1_v = 1; p1_we = 0; p1_a = 32'h20;
    step();
    chk("m1_alone_gnt", 32'(m1_gnt), 32'd1);
    step();
    step();
    chk("m1_alone_rdata", m1_rdata, 32'h1234_5678);
    chk("m1_alone_rv0", 32'(m0_rvalid), 32'd0);

    // Back-to-back reads from alternating masters
    p0_v = 1; p0_we = 0; p0_a = 32'h0;
    step();
    p1_v = 1; p1_we = 0; p1_a = 32'h4;
    step();
    p0_v = 1; p0_we = 0; p0_a = 32'h8;
    step();
    step(); step(); step();

    // Reset during the issue cycle of an accepted write
    p0_v = 1; p0_we = 1; p0_a = 32'h30; p0_d = 32'hAAAA_5555;
    step();
    @(negedge clk);
    t++;
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    reset = 1'b1;
    #1;
    chk_zero("reset_mid");
    foreach (q[i]) if (q[i].acc == t - 1 && q[i].we) shadow[q[i].addr[7:2]] = q[i].old;
    q.delete();
    run = 0; pc0 = 0; pc1 = 0; pcc = 0;
    p1_v = 0;
    @(negedge clk);
    t++;
    m1_req = 0;
    reset = 1'b0;
    #1;
    chk("reset_drop_write", mem[12], 32'h0BAD_F00D);
    step();

    // Randomized traffic from both masters
    for (int i = 0; i < 400; i++) begin
      if (!p0_v && $urandom_range(0, 3) != 0) begin
        p0_v = 1; p0_we = 1'($urandom_range(0, 1));
        p0_a = 32'($urandom_range(0, 15)) << 2; p0_d = $urandom;
      end
      if (!p1_v && $urandom_range(0, 1) != 0) begin
        p1_v = 1; p1_we = 1'($urandom_range(0, 1));
        p1_a = 32'($urandom_range(0, 15)) << 2; p1_d = $urandom;
      end
      step();
    end
    p0_v = 0; p1_v = 0;
    step(); step(); step();

`ifdef DMEM_ARB_PERF_EN
    chk("perf_m0", 32'(perf_m0_cnt), 32'(pc0));
    chk("perf_m1", 32'(perf_m1_cnt), 32'(pc1));
    chk("perf_conflict", 32'(perf_conflict_cnt), 32'(pcc));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
